// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the 3x3 convolver front end.
// The feeder and the convolver both import this package.
package conv_pkg;

  localparam int unsigned BIT_LEN = 8;
  localparam int unsigned M_LEN   = 3;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] K_LOAD = 3'd1;
  localparam logic [2:0] FILL   = 3'd2;
  localparam logic [2:0] STREAM = 3'd3;
  localparam logic [2:0] FLUSH  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  typedef enum logic [2:0] {
    StIdle   = IDLE,
    StKLoad  = K_LOAD,
    StFill   = FILL,
    StStream = STREAM,
    StFlush  = FLUSH,
    StDone   = DONE
  } feeder_state_e;

  localparam logic SEL_KERNEL = 1'b0;
  localparam logic SEL_IMAGE  = 1'b1;

endpackage

// File: rtl/conv_line_buffer.sv
// Two line buffers of IMG_W pixels. A write at address x shifts the column up
// (lb0[x] <= lb1[x], lb1[x] <= data); both rows at x are read combinationally.
module conv_line_buffer #(
  parameter int unsigned BIT_LEN = 8,
  parameter int unsigned IMG_W   = 64,
  parameter int unsigned X_LEN   = $clog2(IMG_W)
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [X_LEN-1:0]   addr_i,
  input  logic [BIT_LEN-1:0] data_i,
  output logic [BIT_LEN-1:0] row0_o,
  output logic [BIT_LEN-1:0] row1_o
);

  logic [BIT_LEN-1:0] lb0_q [IMG_W];
  logic [BIT_LEN-1:0] lb1_q [IMG_W];

  // Contents are never reset; the fill phase of every frame overwrites them.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      lb0_q[addr_i] <= lb1_q[addr_i];
      lb1_q[addr_i] <= data_i;
    end
  end

  assign row0_o = lb0_q[addr_i];
  assign row1_o = lb1_q[addr_i];

endmodule

// File: rtl/conv_line_feeder.sv
// Feeds kernel and image columns to the 3x3 convolver and tracks which
// convolver outputs are genuine windows (result valid plus coordinates).
module conv_line_feeder #(
  parameter int unsigned BIT_LEN = 8,
  parameter int unsigned IMG_W   = 64,
  parameter int unsigned IMG_H   = 64,
  parameter int unsigned X_LEN   = $clog2(IMG_W),
  parameter int unsigned Y_LEN   = $clog2(IMG_H)
) (
  input  logic               CLK100MHZ,
  input  logic               i_reset,
  input  logic               i_load_k,
  input  logic               i_start,
  input  logic [BIT_LEN-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [BIT_LEN-1:0] o_dato0,
  output logic [BIT_LEN-1:0] o_dato1,
  output logic [BIT_LEN-1:0] o_dato2,
  output logic               o_selecK_I,
  output logic               o_conv_valid,
  output logic               o_res_valid,
  output logic [X_LEN-1:0]   o_res_x,
  output logic [Y_LEN-1:0]   o_res_y,
  output logic               o_done
);

  import conv_pkg::*;

  localparam logic [X_LEN-1:0] XMax = X_LEN'(IMG_W - 1);
  localparam logic [Y_LEN-1:0] YMax = Y_LEN'(IMG_H - 1);

  feeder_state_e state_q, state_d;

  logic [X_LEN-1:0]   x_q, x_d;
  logic [Y_LEN-1:0]   y_q, y_d;
  logic [1:0]         kcnt_q, kcnt_d;
  logic [1:0]         kcol_q, kcol_d;
  logic [BIT_LEN-1:0] ktop_q, ktop_d;
  logic [BIT_LEN-1:0] kmid_q, kmid_d;
  logic [1:0]         run_q, run_d;
  logic [X_LEN-1:0]   last_x_q, last_x_d;
  logic [Y_LEN-1:0]   last_y_q, last_y_d;
  logic               pend_valid_q, pend_valid_d;
  logic [X_LEN-1:0]   pend_x_q, pend_x_d;
  logic [Y_LEN-1:0]   pend_y_q, pend_y_d;

  logic               ready_q, ready_d;
  logic [BIT_LEN-1:0] dato0_q, dato0_d;
  logic [BIT_LEN-1:0] dato1_q, dato1_d;
  logic [BIT_LEN-1:0] dato2_q, dato2_d;
  logic               sel_q, sel_d;
  logic               cv_q, cv_d;
  logic               res_valid_q, res_valid_d;
  logic [X_LEN-1:0]   res_x_q, res_x_d;
  logic [Y_LEN-1:0]   res_y_q, res_y_d;
  logic               done_q, done_d;

  logic               accept;
  logic               row_end;
  logic               lb_we;
  logic [BIT_LEN-1:0] lb_row0;
  logic [BIT_LEN-1:0] lb_row1;

  assign accept  = i_valid & ready_q;
  assign row_end = (x_q == XMax);

  conv_line_buffer #(
    .BIT_LEN (BIT_LEN),
    .IMG_W   (IMG_W),
    .X_LEN   (X_LEN)
  ) u_line_buffer (
    .clk_i  (CLK100MHZ),
    .we_i   (lb_we),
    .addr_i (x_q),
    .data_i (i_data),
    .row0_o (lb_row0),
    .row1_o (lb_row1)
  );

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    kcnt_d       = kcnt_q;
    kcol_d       = kcol_q;
    ktop_d       = ktop_q;
    kmid_d       = kmid_q;
    run_d        = run_q;
    last_x_d     = last_x_q;
    last_y_d     = last_y_q;
    pend_valid_d = 1'b0;
    pend_x_d     = pend_x_q;
    pend_y_d     = pend_y_q;
    dato0_d      = dato0_q;
    dato1_d      = dato1_q;
    dato2_d      = dato2_q;
    sel_d        = sel_q;
    cv_d         = 1'b0;
    done_d       = 1'b0;
    res_valid_d  = pend_valid_q;
    res_x_d      = pend_x_q;
    res_y_d      = pend_y_q;
    lb_we        = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_load_k) begin
          state_d = StKLoad;
          kcnt_d  = 2'd0;
          kcol_d  = 2'd0;
        end else if (i_start) begin
          state_d = StFill;
          x_d     = '0;
          y_d     = '0;
          run_d   = 2'd0;
        end
      end
      StKLoad: begin
        if (accept) begin
          case (kcnt_q)
            2'd0: begin
              ktop_d = i_data;
              kcnt_d = 2'd1;
            end
            2'd1: begin
              kmid_d = i_data;
              kcnt_d = 2'd2;
            end
            default: begin
              dato0_d = ktop_q;
              dato1_d = kmid_q;
              dato2_d = i_data;
              sel_d   = SEL_KERNEL;
              cv_d    = 1'b1;
              kcnt_d  = 2'd0;
              if (kcol_q == 2'(M_LEN - 1)) begin
                state_d = StIdle;
              end else begin
                kcol_d = kcol_q + 2'd1;
              end
            end
          endcase
        end
      end
      StFill: begin
        if (accept) begin
          lb_we = 1'b1;
          if (row_end) begin
            x_d = '0;
            y_d = y_q + 1'b1;
            if (y_q == Y_LEN'(1)) begin
              state_d = StStream;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      StStream: begin
        if (accept) begin
          lb_we   = 1'b1;
          dato0_d = lb_row0;
          dato1_d = lb_row1;
          dato2_d = i_data;
          sel_d   = SEL_IMAGE;
          cv_d    = 1'b1;
          // Three consecutive columns of one row precede this strobe: a window is latched.
          pend_valid_d = (run_q == 2'd3);
          pend_x_d     = last_x_q - X_LEN'(2);
          pend_y_d     = last_y_q - Y_LEN'(2);
          if (x_q == '0) begin
            run_d = 2'd1;
          end else if (run_q != 2'd3) begin
            run_d = run_q + 2'd1;
          end
          last_x_d = x_q;
          last_y_d = y_q;
          if (row_end) begin
            x_d = '0;
            if (y_q == YMax) begin
              y_d     = '0;
              state_d = StFlush;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      StFlush: begin
        dato0_d      = '0;
        dato1_d      = '0;
        dato2_d      = '0;
        sel_d        = SEL_IMAGE;
        cv_d         = 1'b1;
        pend_valid_d = (run_q == 2'd3);
        pend_x_d     = last_x_q - X_LEN'(2);
        pend_y_d     = last_y_q - Y_LEN'(2);
        state_d      = StDone;
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StKLoad) || (state_d == StFill) || (state_d == StStream);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (i_reset) begin
      state_q      <= StIdle;
      x_q          <= '0;
      y_q          <= '0;
      kcnt_q       <= '0;
      kcol_q       <= '0;
      ktop_q       <= '0;
      kmid_q       <= '0;
      run_q        <= '0;
      last_x_q     <= '0;
      last_y_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      ready_q      <= 1'b0;
      dato0_q      <= '0;
      dato1_q      <= '0;
      dato2_q      <= '0;
      sel_q        <= 1'b0;
      cv_q         <= 1'b0;
      res_valid_q  <= 1'b0;
      res_x_q      <= '0;
      res_y_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      kcnt_q       <= kcnt_d;
      kcol_q       <= kcol_d;
      ktop_q       <= ktop_d;
      kmid_q       <= kmid_d;
      run_q        <= run_d;
      last_x_q     <= last_x_d;
      last_y_q     <= last_y_d;
      pend_valid_q <= pend_valid_d;
      pend_x_q     <= pend_x_d;
      pend_y_q     <= pend_y_d;
      ready_q      <= ready_d;
      dato0_q      <= dato0_d;
      dato1_q      <= dato1_d;
      dato2_q      <= dato2_d;
      sel_q        <= sel_d;
      cv_q         <= cv_d;
      res_valid_q  <= res_valid_d;
      res_x_q      <= res_x_d;
      res_y_q      <= res_y_d;
      done_q       <= done_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_dato0      = dato0_q;
  assign o_dato1      = dato1_q;
  assign o_dato2      = dato2_q;
  assign o_selecK_I   = sel_q;
  assign o_conv_valid = cv_q;
  assign o_res_valid  = res_valid_q;
  assign o_res_x      = res_x_q;
  assign o_res_y      = res_y_q;
  assign o_done       = done_q;

endmodule

// File: doc/conv_line_feeder.md
Name: conv_line_feeder

Overview:
- Upstream stage of the 3x3 convolver. Takes a raster-order 8-bit pixel stream plus a 9-byte kernel load.
- Holds two line buffers and emits one 3-pixel column per accepted pixel on the convolver's column inputs, with the kernel/image select and the valid strobe.
- Also generates the result-valid strobe and window coordinates, so downstream logic knows when the convolver's latched output is a genuine window.

Parameters:
- BIT_LEN, 8, pixel/kernel coefficient width
- IMG_W, 64, image width in pixels (>=4)
- IMG_H, 64, image height in rows (>=3)
- X_LEN, $clog2(IMG_W), column counter width
- Y_LEN, $clog2(IMG_H), row counter width

Ports:
- CLK100MHZ  in  1  clock, all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_load_k  in  1  one-cycle pulse in IDLE: start kernel load
- i_start  in  1  one-cycle pulse in IDLE: start image frame
- i_data  in  BIT_LEN  kernel byte or pixel
- i_valid  in  1  i_data valid; accepted when i_valid & o_ready
- o_ready  out  1  feeder can accept i_data this cycle
- o_dato0  out  BIT_LEN  top row (row r-2 / kernel row 0)
- o_dato1  out  BIT_LEN  middle row (r-1 / kernel row 1)
- o_dato2  out  BIT_LEN  bottom row (r / kernel row 2)
- o_selecK_I  out  1  0 = kernel column, 1 = image column
- o_conv_valid  out  1  column strobe to the convolver
- o_res_valid  out  1  convolver o_data holds a valid window result this cycle
- o_res_x  out  X_LEN  output column of that result (0..IMG_W-3)
- o_res_y  out  Y_LEN  output row of that result (0..IMG_H-3)
- o_done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset: state IDLE; every output 0, including o_ready and o_selecK_I; all counters 0. Line-buffer contents are not cleared; FILL overwrites them.
- Reset mid-operation aborts at the next edge. The convolver shares i_reset, so its kernel also returns to its default.
- All outputs are registered. A column appears the cycle after its bottom pixel is accepted.
- FSM states: IDLE, K_LOAD, FILL, STREAM, FLUSH, DONE.
- IDLE:
  - o_ready=0.
  - i_load_k -> K_LOAD.
  - i_start -> FILL.
  - Both high together: i_load_k wins and i_start is dropped.
  - i_load_k/i_start are ignored outside IDLE.
- K_LOAD:
  - o_ready=1. Accepts 9 bytes in column order: col0 top/mid/bot, col1 ..., col2 ....
  - After each 3rd byte, emit one strobe: o_selecK_I=0, o_conv_valid=1, dato0/1/2 = top/mid/bot.
  - After the 9th byte, the 3rd strobe issues -> IDLE.
- FILL:
  - o_ready=1. Accepts 2*IMG_W pixels: row 0 -> lb0, row 1 -> lb1. No strobes.
  - -> STREAM after the last pixel of row 1.
- STREAM:
  - o_ready=1. For a pixel accepted at column x of row r (r>=2), the next cycle drives o_dato0=lb0[x], o_dato1=lb1[x], o_dato2=pixel, o_selecK_I=1, o_conv_valid=1.
  - In the same edge: lb0[x]<=lb1[x], lb1[x]<=pixel.
  - x wraps IMG_W-1 -> 0 with r+1.
  - After the last pixel (x=IMG_W-1, r=IMG_H-1) -> FLUSH.
- FLUSH:
  - o_ready=0. Emits one zero column (sel=1, valid=1), solely to latch the final window. -> DONE.
- DONE: o_done=1 for one cycle -> IDLE.
- Gaps in i_valid insert idle cycles with o_conv_valid=0; the column sequence is unaffected.
- Result tracking:
  - The convolver latches, at strobe k, the window formed by strobes k-3..k-1. run = image strobes since the current row's first strobe, saturating at 3.
  - A strobe produces a result when, before it, run==3 and the previous 3 strobes were columns x-3..x-1 of one row. This covers strobe at column 0 of the next row (previous row's last window) and the FLUSH strobe.
  - o_res_valid is high the cycle after such a strobe, i.e. 2 cycles after the accepting edge.
  - o_res_x = last window column - 2; o_res_y = window bottom row - 2.
  - Total per frame: (IMG_W-2)*(IMG_H-2) results.
- Kernel strobes never assert o_res_valid.

Decomposition:
- Shared package conv_pkg:
  - BIT_LEN and M_LEN=3 constants.
  - State encoding localparams (IDLE=0..DONE=5).
  - SEL_KERNEL=0, SEL_IMAGE=1.
- One natural sub-module, conv_line_buffer: IMG_W x BIT_LEN dual-row shift storage, write-and-shift at address x, combinational read of lb0[x], lb1[x].

Test Plan (bench IMG_W=5, IMG_H=4, pixel = 10*row+col):
- Kernel load bytes 1..9 -> three strobes, sel=0: (dato0,1,2) = (1,2,3), (4,5,6), (7,8,9); o_res_valid stays 0; then IDLE.
- Full frame -> no strobes during the first 10 pixels. First strobe (0,10,20); strobe at row 3 col 4 = (14,24,34).
- Same frame -> exactly 6 o_res_valid pulses, with (x,y) = (0,0), (1,0), (2,0), (0,1), (1,1), (2,1).
- Same frame -> last result (2,1) coincides with the FLUSH strobe; o_done one cycle after FLUSH.
- Same frame with a convolver attached and an identity-centre kernel -> o_data centre pixel values 11, 12, 13, 21, 22, 23.
- i_valid toggling 1/0 -> identical strobe and result sequence, spread out in time.
- i_reset asserted mid-STREAM -> next cycle all outputs 0, state IDLE. A new i_start runs a clean frame with correct results.
- i_load_k and i_start in the same cycle -> K_LOAD entered; i_start ignored.
